// File: rtl/mem_rr_arbiter_if.sv
// Shared-memory arbiter bus bundle: per-requester request slices on one side,
// the single q_m memory bus on the other. The arbiter takes the slave view;
// the requesters and the memory decode together take the master view.
interface mem_rr_arbiter_if #(
  parameter int NREQ = 3
);

  // Requester side, packed slices indexed by requester number
  logic [NREQ-1:0]    req_access;
  logic [NREQ*19-1:0] req_addr;
  logic [NREQ*16-1:0] req_data_out;
  logic [NREQ-1:0]    req_wr_en;
  logic [NREQ*2-1:0]  req_bytesel;
  logic [NREQ-1:0]    req_ack;
  logic [15:0]        req_data_in;

  // Shared q_m memory bus side
  logic [18:0]        q_m_addr;
  logic [15:0]        q_m_data_out;
  logic               q_m_wr_en;
  logic [1:0]         q_m_bytesel;
  logic               q_m_access;
  logic               q_m_ack;
  logic [15:0]        q_m_data_in;

  modport slave (
    input  req_access, req_addr, req_data_out, req_wr_en, req_bytesel,
    output req_ack, req_data_in,
    output q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel, q_m_access,
    input  q_m_ack, q_m_data_in
  );

  modport master (
    output req_access, req_addr, req_data_out, req_wr_en, req_bytesel,
    input  req_ack, req_data_in,
    input  q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel, q_m_access,
    output q_m_ack, q_m_data_in
  );

endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing the q_m memory bus between the Core instruction
// bus (0), Core data bus (1) and DMA/blitter (2). A grant is held until the
// slave acks; a watchdog forces completion if the slave never answers, and a
// one-cycle DRAIN state soaks up late acks after a timeout or an abort.
module mem_rr_arbiter #(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 64
) (
  input  logic            sys_clk,
  input  logic            reset,
  mem_rr_arbiter_if.slave bus,
  output logic [NREQ-1:0] grant,
  output logic            timeout_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_grant;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_last;
  logic [TW-1:0]   r_tcnt;
  logic            r_timeoutErr;

  logic            w_winFound;
  logic [IW-1:0]   w_winIdx;
  int              w_scanIdx;
  logic            w_busy;
  logic            w_ownReq;
  logic            w_done;
  logic            w_abort;
  logic            w_timeout;
  int              w_addrBase;
  int              w_dataBase;
  int              w_selBase;

  assign grant       = r_grant;
  assign timeout_err = r_timeoutErr;

  // Round-robin winner: first requester found scanning upward from last+1
  always_comb begin
    w_winFound = 1'b0;
    w_winIdx   = '0;
    w_scanIdx  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_scanIdx = (int'(r_last) + k) % NREQ;
      if (!w_winFound && bus.req_access[w_scanIdx]) begin
        w_winFound = 1'b1;
        w_winIdx   = IW'(w_scanIdx);
      end
    end
  end

  // Owner status in BUSY: abort wins over ack, ack wins over the watchdog
  always_comb begin
    w_busy    = (r_state == ST_BUSY);
    w_ownReq  = bus.req_access[r_owner];
    w_abort   = w_busy & ~w_ownReq;
    w_done    = w_busy &  w_ownReq &  bus.q_m_ack;
    w_timeout = w_busy &  w_ownReq & ~bus.q_m_ack & (r_tcnt == TLAST);
  end

  // Shared bus mux: owner's slice while BUSY, all zero otherwise
  always_comb begin
    w_addrBase       = 19 * int'(r_owner);
    w_dataBase       = 16 * int'(r_owner);
    w_selBase        = 2 * int'(r_owner);
    bus.q_m_addr     = '0;
    bus.q_m_data_out = '0;
    bus.q_m_wr_en    = 1'b0;
    bus.q_m_bytesel  = '0;
    bus.q_m_access   = 1'b0;
    if (w_busy) begin
      bus.q_m_addr     = bus.req_addr[w_addrBase +: 19];
      bus.q_m_data_out = bus.req_data_out[w_dataBase +: 16];
      bus.q_m_wr_en    = bus.req_wr_en[r_owner];
      bus.q_m_bytesel  = bus.req_bytesel[w_selBase +: 2];
      bus.q_m_access   = w_ownReq & ~bus.q_m_ack;
    end
  end

  // Completion back to the owner: slave data on ack, all-ones on timeout
  always_comb begin
    bus.req_ack     = '0;
    bus.req_data_in = '0;
    if (w_done) begin
      bus.req_ack     = NREQ'(1) << r_owner;
      bus.req_data_in = bus.q_m_data_in;
    end else if (w_timeout) begin
      bus.req_ack     = NREQ'(1) << r_owner;
      bus.req_data_in = 16'hFFFF;
    end
  end

  // Arbitration FSM: grant in IDLE, hold through BUSY, one DRAIN cycle after faults
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_owner      <= '0;
      r_last       <= IW'(NREQ - 1);
      r_tcnt       <= '0;
      r_timeoutErr <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_winFound) begin
            r_grant <= NREQ'(1) << w_winIdx;
            r_owner <= w_winIdx;
            r_tcnt  <= '0;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_abort) begin
            r_grant <= '0;
            r_state <= ST_DRAIN;
          end else if (w_done) begin
            r_last  <= r_owner;
            r_grant <= '0;
            r_state <= ST_IDLE;
          end else if (w_timeout) begin
            r_timeoutErr <= 1'b1;
            r_last       <= r_owner;
            r_grant      <= '0;
            r_state      <= ST_DRAIN;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_grant <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: single read, round-robin rotation,
// write muxing, watchdog timeout, requester abort and mid-transfer reset.
module tb_mem_rr_arbiter;

  localparam int NREQ = 3;
  localparam int TO   = 8;

  logic            sys_clk;
  logic            reset;
  logic [NREQ-1:0] grant;
  logic            timeout_err;

  int compared;
  int mismatched;
  int ackCnt [NREQ];

  mem_rr_arbiter_if #(.NREQ(NREQ)) bus ();

  mem_rr_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .bus         (bus),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  // Free-running 100 MHz clock
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock; land 2 time units after the edge, clear of it
  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  // Drive requester lines and the slave ack/data, then let logic settle
  task automatic applyStimulus(input logic [NREQ-1:0] req, input logic ack,
                               input logic [15:0] ackData);
    bus.req_access  = req;
    bus.q_m_ack     = ack;
    bus.q_m_data_in = ackData;
    #1;
  endtask

  // One comparison: count it, assert it, report it on failure
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < NREQ; i++) ackCnt[i] = 0;
    reset            = 1'b1;
    bus.req_access   = '0;
    bus.req_addr     = '0;
    bus.req_data_out = '0;
    bus.req_wr_en    = '0;
    bus.req_bytesel  = '0;
    bus.q_m_ack      = 1'b0;
    bus.q_m_data_in  = '0;
    #3;

    $display("[TB] reset state");
    checkOutput("rst_grant", 32'(grant), 32'h0);
    checkOutput("rst_access", 32'(bus.q_m_access), 32'h0);
    checkOutput("rst_req_ack", 32'(bus.req_ack), 32'h0);
    checkOutput("rst_data_in", 32'(bus.req_data_in), 32'h0);
    checkOutput("rst_addr", 32'(bus.q_m_addr), 32'h0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'h0);
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] single read by req1");
    bus.req_addr[19*0 +: 19] = 19'h7FFFF;
    bus.req_addr[19*1 +: 19] = 19'h00010;
    applyStimulus(3'b010, 1'b0, 16'h0);
    checkOutput("rd_idle_access", 32'(bus.q_m_access), 32'h0);
    tick();
    checkOutput("rd_grant", 32'(grant), 32'h2);
    checkOutput("rd_access", 32'(bus.q_m_access), 32'h1);
    checkOutput("rd_addr", 32'(bus.q_m_addr), 32'h00010);
    checkOutput("rd_no_ack_yet", 32'(bus.req_ack), 32'h0);
    tick();
    applyStimulus(3'b010, 1'b1, 16'hBEEF);
    checkOutput("rd_req_ack", 32'(bus.req_ack), 32'h2);
    checkOutput("rd_data_in", 32'(bus.req_data_in), 32'hBEEF);
    checkOutput("rd_access_on_ack", 32'(bus.q_m_access), 32'h0);
    tick();
    applyStimulus(3'b000, 1'b0, 16'h0);
    checkOutput("rd_after_grant", 32'(grant), 32'h0);
    checkOutput("rd_after_data", 32'(bus.req_data_in), 32'h0);

    $display("[TB] write by req2");
    bus.req_data_out[16*1 +: 16] = 16'hFFFF;
    bus.req_data_out[16*2 +: 16] = 16'h00A5;
    bus.req_addr[19*2 +: 19]     = 19'h12345;
    bus.req_wr_en                = 3'b100;
    bus.req_bytesel              = 6'b01_11_11;
    applyStimulus(3'b100, 1'b0, 16'h0);
    tick();
    checkOutput("wr_grant", 32'(grant), 32'h4);
    checkOutput("wr_wr_en", 32'(bus.q_m_wr_en), 32'h1);
    checkOutput("wr_bytesel", 32'(bus.q_m_bytesel), 32'h1);
    checkOutput("wr_data_out", 32'(bus.q_m_data_out), 32'h00A5);
    checkOutput("wr_addr", 32'(bus.q_m_addr), 32'h12345);
    applyStimulus(3'b100, 1'b1, 16'h0);
    checkOutput("wr_req_ack", 32'(bus.req_ack), 32'h4);
    tick();
    applyStimulus(3'b000, 1'b0, 16'h0);
    bus.req_wr_en   = '0;
    bus.req_bytesel = '0;

    $display("[TB] round robin with all requesters held");
    reset = 1'b1;
    #1;
    reset = 1'b0;
    applyStimulus(3'b111, 1'b0, 16'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("rr_grant", 32'(grant), 32'(1 << (k % 3)));
      applyStimulus(3'b111, 1'b1, 16'(16'h1000 + k));
      checkOutput("rr_req_ack", 32'(bus.req_ack), 32'(1 << (k % 3)));
      checkOutput("rr_data_in", 32'(bus.req_data_in), 32'(16'h1000 + k));
      for (int i = 0; i < NREQ; i++) if (bus.req_ack[i]) ackCnt[i]++;
      tick();
      applyStimulus(3'b111, 1'b0, 16'h0);
      checkOutput("rr_idle_grant", 32'(grant), 32'h0);
    end
    for (int i = 0; i < NREQ; i++) checkOutput("rr_ack_share", 32'(ackCnt[i]), 32'd2);
    applyStimulus(3'b000, 1'b0, 16'h0);

    $display("[TB] watchdog timeout on req0");
    applyStimulus(3'b001, 1'b0, 16'h0);
    tick();
    checkOutput("to_grant", 32'(grant), 32'h1);
    for (int i = 0; i < TO - 1; i++) begin
      checkOutput("to_wait_ack", 32'(bus.req_ack), 32'h0);
      tick();
    end
    checkOutput("to_req_ack", 32'(bus.req_ack), 32'h1);
    checkOutput("to_data_in", 32'(bus.req_data_in), 32'hFFFF);
    checkOutput("to_err_not_yet", 32'(timeout_err), 32'h0);
    tick();
    applyStimulus(3'b001, 1'b0, 16'h0);
    checkOutput("to_drain_grant", 32'(grant), 32'h0);
    checkOutput("to_drain_access", 32'(bus.q_m_access), 32'h0);
    checkOutput("to_drain_ack", 32'(bus.req_ack), 32'h0);
    checkOutput("to_err", 32'(timeout_err), 32'h1);
    tick();
    checkOutput("to_idle_grant", 32'(grant), 32'h0);
    tick();
    checkOutput("to_regrant", 32'(grant), 32'h1);
    applyStimulus(3'b001, 1'b1, 16'h5A5A);
    checkOutput("to_regrant_data", 32'(bus.req_data_in), 32'h5A5A);
    tick();
    applyStimulus(3'b000, 1'b0, 16'h0);
    checkOutput("to_err_sticky", 32'(timeout_err), 32'h1);

    $display("[TB] abort by req1 with req2 pending");
    applyStimulus(3'b110, 1'b0, 16'h0);
    tick();
    checkOutput("ab_grant", 32'(grant), 32'h2);
    tick();
    applyStimulus(3'b100, 1'b0, 16'h0);
    checkOutput("ab_access", 32'(bus.q_m_access), 32'h0);
    checkOutput("ab_no_ack", 32'(bus.req_ack), 32'h0);
    tick();
    applyStimulus(3'b100, 1'b1, 16'h1234);
    checkOutput("ab_drain_ack", 32'(bus.req_ack), 32'h0);
    checkOutput("ab_drain_data", 32'(bus.req_data_in), 32'h0);
    checkOutput("ab_drain_grant", 32'(grant), 32'h0);
    tick();
    applyStimulus(3'b100, 1'b0, 16'h0);
    checkOutput("ab_idle_grant", 32'(grant), 32'h0);
    tick();
    checkOutput("ab_next_grant", 32'(grant), 32'h4);
    applyStimulus(3'b100, 1'b1, 16'h0);
    tick();
    applyStimulus(3'b000, 1'b0, 16'h0);

    $display("[TB] reset while busy with req0");
    applyStimulus(3'b001, 1'b0, 16'h0);
    tick();
    checkOutput("rb_grant", 32'(grant), 32'h1);
    applyStimulus(3'b001, 1'b1, 16'h7777);
    checkOutput("rb_req_ack", 32'(bus.req_ack), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("rb_access", 32'(bus.q_m_access), 32'h0);
    checkOutput("rb_grant_clr", 32'(grant), 32'h0);
    checkOutput("rb_ack_clr", 32'(bus.req_ack), 32'h0);
    checkOutput("rb_data_clr", 32'(bus.req_data_in), 32'h0);
    checkOutput("rb_err_clr", 32'(timeout_err), 32'h0);
    reset = 1'b0;
    applyStimulus(3'b001, 1'b0, 16'h0);
    tick();
    checkOutput("rb_regrant", 32'(grant), 32'h1);
    applyStimulus(3'b000, 1'b0, 16'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
